// File: rtl/pipe_ctrl5_if.sv
// Handshake/bus bundle between the pipeline control core and the datapath/ROM.
interface pipe_ctrl5_if #(
    parameter int PC_W = 8,
    parameter int IW   = 32
);
    logic [PC_W-1:0] imem_addr;
    logic [IW-1:0]   imem_q;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic [IW-1:0]   ir_id;
    logic [IW-1:0]   ir_ex;
    logic [IW-1:0]   ir_mem;
    logic [IW-1:0]   ir_wb;
    logic [PC_W-1:0] pc_ex;
    logic [3:0]      vld;
    logic            stall;
    logic            flush;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic            halted;

    modport master (
        input  imem_q, br_taken, br_target,
        output imem_addr, ir_id, ir_ex, ir_mem, ir_wb, pc_ex, vld,
               stall, flush, fwd_a, fwd_b, wb_we, wb_rd, halted
    );

    modport slave (
        output imem_q, br_taken, br_target,
        input  imem_addr, ir_id, ir_ex, ir_mem, ir_wb, pc_ex, vld,
               stall, flush, fwd_a, fwd_b, wb_we, wb_rd, halted
    );
endinterface

// File: rtl/pipe_ctrl5.sv
// Control/sequencing core of a 5-stage MIPS pipeline: PC and ROM addressing,
// IR/valid chain, load-use interlock, branch flush, forwarding and HALT drain.
//
// state   | meaning
// S_RUN   | fetching normally
// S_DRAIN | HALT left ID, fetch frozen, waiting for HALT to retire
// S_DONE  | HALT retired, pipeline empty, halted=1 until rst
module pipe_ctrl5 #(
    parameter int PC_W     = 8,
    parameter int IW       = 32,
    parameter int RESET_PC = 0
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl5_if.master bus
);
    localparam logic [PC_W-1:0] RST_PC  = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
    localparam logic [5:0]      OP_RTYP = 6'b000000;
    localparam logic [5:0]      OP_LW   = 6'b100011;
    localparam logic [5:0]      OP_SW   = 6'b101011;
    localparam logic [5:0]      OP_BEQ  = 6'b000100;
    localparam logic [5:0]      OP_HALT = 6'b111111;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} run_t;
    run_t state, state_nx;

    logic [PC_W-1:0] pc, addr_q, pc_id, pc_ex, imem_addr;
    logic            fetch_vld;
    logic [IW-1:0]   ir_id, ir_ex, ir_mem, ir_wb;
    logic [3:0]      vld;
    logic            load_use, stall, flush, halt_id, halt_wb, halt_go;
    logic            fetch_stop, halted;
    logic [4:0]      mem_dst, wb_dst, rs_ex, rt_ex;
    logic [1:0]      fwd_a, fwd_b;

    function automatic logic [5:0] op_of(input logic [IW-1:0] ir);
        return ir[IW-1 -: 6];
    endfunction

    // Destination register; 0 doubles as "no destination".
    function automatic logic [4:0] dest_of(input logic [IW-1:0] ir);
        logic [4:0] d;
        casez (ir[IW-1 -: 6])
            6'b000000: d = ir[15:11];
            6'b001???: d = ir[20:16];
            6'b100011: d = ir[20:16];
            default:   d = 5'd0;
        endcase
        return d;
    endfunction

    function automatic logic reads_rt(input logic [IW-1:0] ir);
        return (op_of(ir) == OP_RTYP) || (op_of(ir) == OP_SW) || (op_of(ir) == OP_BEQ);
    endfunction

    assign rs_ex = ir_ex[25:21];
    assign rt_ex = ir_ex[20:16];

    // Hazard detection: flush outranks the load-use interlock.
    always_comb begin
        flush    = bus.br_taken & vld[1];
        load_use = vld[1] && (op_of(ir_ex) == OP_LW) && (rt_ex != 5'd0) && vld[0] &&
                   ((rt_ex == ir_id[25:21]) || ((rt_ex == ir_id[20:16]) && reads_rt(ir_id)));
        stall    = load_use & ~flush;
        halt_id  = vld[0] && (op_of(ir_id) == OP_HALT);
        halt_wb  = vld[3] && (op_of(ir_wb) == OP_HALT);
        halt_go  = halt_id & ~flush & ~stall;
    end

    // Run-state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_RUN;
        else     state <= state_nx;
    end

    // Run-state transitions; a flush while draining means the HALT was squashed.
    always_comb begin
        state_nx = state;
        case (state)
            S_RUN:   if (halt_go) state_nx = S_DRAIN;
            S_DRAIN: if (flush) state_nx = S_RUN;
                     else if (halt_wb) state_nx = S_DONE;
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_RUN;
        endcase
    end

    // Run-state outputs: fetch freezes from the cycle HALT sits in ID.
    always_comb begin
        fetch_stop = (state != S_RUN) | halt_go;
        halted     = (state == S_DONE);
    end

    // ROM address: replaying addr_q keeps imem_q valid for the held ID word.
    always_comb begin
        if (flush)                    imem_addr = bus.br_target;
        else if (stall || fetch_stop) imem_addr = addr_q;
        else                          imem_addr = pc;
    end

    // Forwarding selects for EX operands; MEM is the younger producer and wins.
    always_comb begin
        mem_dst = dest_of(ir_mem);
        wb_dst  = dest_of(ir_wb);
        fwd_a   = 2'b00;
        fwd_b   = 2'b00;
        if (vld[2] && mem_dst != 5'd0 && mem_dst == rs_ex)     fwd_a = 2'b10;
        else if (vld[3] && wb_dst != 5'd0 && wb_dst == rs_ex)  fwd_a = 2'b01;
        if (vld[2] && mem_dst != 5'd0 && mem_dst == rt_ex)     fwd_b = 2'b10;
        else if (vld[3] && wb_dst != 5'd0 && wb_dst == rt_ex)  fwd_b = 2'b01;
    end

    // PC, fetch-valid and stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RST_PC;
            addr_q    <= RST_PC;
            fetch_vld <= 1'b0;
            pc_id     <= '0;
            pc_ex     <= '0;
            ir_id     <= '0;
            ir_ex     <= '0;
            ir_mem    <= '0;
            ir_wb     <= '0;
            vld       <= 4'b0000;
        end else begin
            addr_q <= imem_addr;
            ir_mem <= ir_ex;
            ir_wb  <= ir_mem;
            vld[2] <= vld[1];
            vld[3] <= vld[2];
            if (flush) begin
                // Both the ID word and the word returning now are wrong-path.
                pc        <= bus.br_target + PC_ONE;
                fetch_vld <= 1'b1;
                ir_id     <= '0;
                vld[0]    <= 1'b0;
                ir_ex     <= '0;
                vld[1]    <= 1'b0;
            end else if (stall) begin
                ir_ex  <= '0;
                vld[1] <= 1'b0;
            end else begin
                ir_ex  <= ir_id;
                vld[1] <= vld[0];
                pc_ex  <= pc_id;
                if (fetch_stop) begin
                    fetch_vld <= 1'b0;
                    ir_id     <= '0;
                    vld[0]    <= 1'b0;
                end else begin
                    pc        <= pc + PC_ONE;
                    fetch_vld <= 1'b1;
                    ir_id     <= bus.imem_q;
                    vld[0]    <= fetch_vld;
                    pc_id     <= addr_q;
                end
            end
        end
    end

    assign bus.imem_addr = imem_addr;
    assign bus.ir_id     = ir_id;
    assign bus.ir_ex     = ir_ex;
    assign bus.ir_mem    = ir_mem;
    assign bus.ir_wb     = ir_wb;
    assign bus.pc_ex     = pc_ex;
    assign bus.vld       = vld;
    assign bus.stall     = stall;
    assign bus.flush     = flush;
    assign bus.fwd_a     = fwd_a;
    assign bus.fwd_b     = fwd_b;
    assign bus.wb_we     = vld[3] && (wb_dst != 5'd0);
    assign bus.wb_rd     = wb_dst;
    assign bus.halted    = halted;
endmodule

// File: tb/tb_pipe_ctrl5.sv
// Scoreboard bench for pipe_ctrl5: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them as the DUT reaches each cycle.
module tb_pipe_ctrl5;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl5_if #(.PC_W(8), .IW(32)) bus ();
    pipe_ctrl5_if #(.PC_W(4), .IW(32)) bus4 ();

    pipe_ctrl5 #(.PC_W(8), .IW(32), .RESET_PC(0)) dut  (.clk(clk), .rst(rst), .bus(bus.master));
    pipe_ctrl5 #(.PC_W(4), .IW(32), .RESET_PC(0)) dut4 (.clk(clk), .rst(rst), .bus(bus4.master));

    logic [31:0] rom [0:255];
    always @(posedge clk) bus.imem_q <= rom[bus.imem_addr];
    assign bus4.imem_q    = 32'h0;
    assign bus4.br_taken  = 1'b0;
    assign bus4.br_target = 4'h0;

    int cyc = 0;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    localparam int F_ADDR = 0, F_IRID = 1, F_VLD = 2, F_STALL = 3, F_FLUSH = 4, F_FWDA = 5,
                   F_FWDB = 6, F_WBWE = 7, F_WBRD = 8, F_HALT = 9, F_PCEX = 10,
                   F_ADDR4 = 11, F_VLD4 = 12;

    typedef struct {
        int          c;
        int          f;
        logic [31:0] v;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;
    int seg    = 0;

    function automatic string fname(input int f);
        case (f)
            F_ADDR:  return "imem_addr";
            F_IRID:  return "ir_id";
            F_VLD:   return "vld";
            F_STALL: return "stall";
            F_FLUSH: return "flush";
            F_FWDA:  return "fwd_a";
            F_FWDB:  return "fwd_b";
            F_WBWE:  return "wb_we";
            F_WBRD:  return "wb_rd";
            F_HALT:  return "halted";
            F_PCEX:  return "pc_ex";
            F_ADDR4: return "imem_addr_w4";
            default: return "vld_w4";
        endcase
    endfunction

    function automatic logic [31:0] addi(input int rt, input int rs, input int imm);
        return {6'b001000, 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] add(input int rd, input int rs, input int rt);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'b100000};
    endfunction
    function automatic logic [31:0] lw(input int rt, input int off, input int rs);
        return {6'b100011, 5'(rs), 5'(rt), 16'(off)};
    endfunction
    function automatic logic [31:0] beq(input int rs, input int rt, input int off);
        return {6'b000100, 5'(rs), 5'(rt), 16'(off)};
    endfunction
    localparam logic [31:0] HALT = 32'hFC00_0000;

    // Monitor: compare every expectation due at the current cycle.
    exp_t        e;
    logic [31:0] act;
    always @(negedge clk) begin
        if (!rst) begin
            while (sbq.size() > 0 && sbq[0].c <= cyc) begin
                e = sbq.pop_front();
                case (e.f)
                    F_ADDR:  act = 32'(bus.imem_addr);
                    F_IRID:  act = bus.ir_id;
                    F_VLD:   act = 32'(bus.vld);
                    F_STALL: act = 32'(bus.stall);
                    F_FLUSH: act = 32'(bus.flush);
                    F_FWDA:  act = 32'(bus.fwd_a);
                    F_FWDB:  act = 32'(bus.fwd_b);
                    F_WBWE:  act = 32'(bus.wb_we);
                    F_WBRD:  act = 32'(bus.wb_rd);
                    F_HALT:  act = 32'(bus.halted);
                    F_PCEX:  act = 32'(bus.pc_ex);
                    F_ADDR4: act = 32'(bus4.imem_addr);
                    default: act = 32'(bus4.vld);
                endcase
                checks++;
                if (e.c != cyc) begin
                    errors++;
                    $display("FAIL seg%0d %s expected at cycle %0d, not sampled (now %0d)",
                             seg, fname(e.f), e.c, cyc);
                end else if (act !== e.v) begin
                    errors++;
                    $display("FAIL seg%0d %s cycle %0d actual %0h required %0h",
                             seg, fname(e.f), cyc, act, e.v);
                end
            end
        end
    end

    task automatic push(input int c, input int f, input logic [31:0] v);
        sbq.push_back('{c, f, v});
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    endtask

    task automatic reset_checks();
        push(0, F_ADDR, 0);  push(0, F_IRID, 0);  push(0, F_VLD, 0);
        push(0, F_STALL, 0); push(0, F_FLUSH, 0); push(0, F_WBWE, 0);
        push(0, F_HALT, 0);  push(0, F_FWDA, 0);  push(0, F_PCEX, 0);
    endtask

    // Apply reset; returns #1 after the last reset edge, i.e. in cycle 0.
    task automatic start();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step_to(input int n);
        for (int i = 0; i < 200 && cyc != n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL seg%0d timeout: %0d expectations never reached", seg, sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.br_taken  = 1'b0;
        bus.br_target = 8'h00;

        // Straight-line forwarding; also PC_W=4 wrap on the second instance.
        seg = 1;
        clear_rom();
        rom[0] = addi(1, 0, 5); rom[1] = addi(2, 0, 7); rom[2] = add(3, 1, 2);
        reset_checks();
        push(1, F_ADDR, 1);
        push(2, F_ADDR, 2); push(2, F_IRID, addi(1, 0, 5));
        push(3, F_ADDR, 3);
        push(5, F_FWDA, 1); push(5, F_FWDB, 2); push(5, F_VLD, 4'hF);
        push(5, F_WBWE, 1); push(5, F_WBRD, 1); push(5, F_PCEX, 2);
        push(6, F_WBWE, 1); push(6, F_WBRD, 2);
        push(7, F_WBWE, 1); push(7, F_WBRD, 3);
        push(15, F_ADDR4, 15); push(16, F_ADDR4, 0); push(17, F_ADDR4, 1);
        push(17, F_VLD4, 4'hF); push(18, F_VLD4, 4'hF);
        start();
        wait_done();

        // Load-use interlock: one bubble, replayed address, then WB forwarding.
        seg = 2;
        clear_rom();
        rom[0] = lw(4, 0, 0); rom[1] = add(5, 4, 4);
        reset_checks();
        push(2, F_ADDR, 2);  push(2, F_STALL, 0);
        push(3, F_STALL, 1); push(3, F_ADDR, 2);
        push(4, F_STALL, 0); push(4, F_VLD, 4'b0101); push(4, F_ADDR, 3);
        push(4, F_IRID, add(5, 4, 4));
        push(5, F_FWDA, 1); push(5, F_FWDB, 1); push(5, F_VLD, 4'b1011);
        push(5, F_WBWE, 1); push(5, F_WBRD, 4);
        start();
        wait_done();

        // Taken branch in EX.
        seg = 3;
        clear_rom();
        rom[0] = beq(0, 0, 4); rom[1] = addi(7, 0, 1); rom[8'h20] = addi(8, 0, 2);
        reset_checks();
        push(3, F_FLUSH, 1); push(3, F_ADDR, 8'h20); push(3, F_STALL, 0);
        push(4, F_FLUSH, 0); push(4, F_IRID, 0); push(4, F_ADDR, 8'h21);
        push(5, F_IRID, addi(8, 0, 2)); push(5, F_ADDR, 8'h22);
        start();
        step_to(3);
        bus.br_taken = 1'b1; bus.br_target = 8'h20;
        @(posedge clk); #1;
        bus.br_taken = 1'b0; bus.br_target = 8'h00;
        wait_done();

        // Branch flush coinciding with a load-use hazard: flush wins, no stall.
        seg = 4;
        clear_rom();
        rom[0] = lw(4, 0, 0); rom[1] = add(5, 4, 4); rom[8'h20] = addi(9, 0, 3);
        reset_checks();
        push(3, F_FLUSH, 1); push(3, F_STALL, 0); push(3, F_ADDR, 8'h20);
        push(4, F_ADDR, 8'h21); push(4, F_IRID, 0);
        push(5, F_IRID, addi(9, 0, 3));
        start();
        step_to(3);
        bus.br_taken = 1'b1; bus.br_target = 8'h20;
        @(posedge clk); #1;
        bus.br_taken = 1'b0; bus.br_target = 8'h00;
        wait_done();

        // HALT at address 3: fetch freezes, drain, sticky halted.
        seg = 5;
        clear_rom();
        rom[0] = addi(1, 0, 1); rom[1] = addi(2, 0, 2); rom[2] = addi(3, 0, 3); rom[3] = HALT;
        reset_checks();
        push(4, F_ADDR, 4);
        push(5, F_ADDR, 4); push(5, F_IRID, HALT);
        push(6, F_ADDR, 4); push(6, F_IRID, 0);
        push(7, F_VLD, 4'b1100);
        push(8, F_HALT, 0); push(8, F_WBWE, 0);
        push(9, F_HALT, 1); push(9, F_ADDR, 4);
        push(12, F_HALT, 1); push(12, F_ADDR, 4);
        start();
        wait_done();

        // After reset from halted: r0 writes suppressed, then MEM-over-WB priority.
        seg = 6;
        clear_rom();
        rom[0] = addi(0, 0, 1); rom[1] = add(6, 0, 0);
        rom[2] = addi(1, 0, 1); rom[3] = addi(1, 0, 2); rom[4] = add(10, 1, 1);
        reset_checks();
        push(1, F_ADDR, 1);
        push(4, F_FWDA, 0); push(4, F_FWDB, 0);
        push(5, F_WBWE, 0); push(5, F_WBRD, 0);
        push(6, F_WBWE, 1); push(6, F_WBRD, 6);
        push(7, F_FWDA, 2); push(7, F_FWDB, 2);
        start();
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
